// File: rtl/square_wave_gen.sv
// Programmable square wave generator with a one-deep pending configuration register.
// Latency: config applied 1 cycle after acceptance in IDLE/HOLD, at the period boundary in RUN; sq_out lags cnt by 1 cycle.
// Backpressure: cfg_ready is low while a configuration is pending; offers made while low are ignored.
module square_wave_gen #(
    parameter int CNT_W = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             sq_out,
    output logic             period_tick,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] act_period;
    logic [CNT_W-1:0] act_high;
    logic [CNT_W-1:0] pend_period;
    logic [CNT_W-1:0] pend_high;
    logic             pend_vld;
    logic             apply;
    logic             accept;
    logic             boundary;
    logic [CNT_W-1:0] eff_period;
    logic             sq_nxt;
    logic             tick_nxt;

    // A configuration can only be taken when the pending slot is empty.
    assign cfg_ready = ~pend_vld;
    assign accept    = cfg_valid & ~pend_vld;

    // Last cycle of the running period; RUN guarantees act_period >= 2 so the subtraction cannot wrap.
    assign boundary  = (state == RUN) && (cnt == act_period - ONE);

    // In IDLE the decision to start uses the configuration that is being applied this cycle, if any.
    assign eff_period = pend_vld ? pend_period : act_period;

    // Next-state, counter and apply decision for the wave FSM.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        apply     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                apply   = pend_vld;
                if (en) begin
                    state_nxt = (eff_period >= TWO) ? RUN : HOLD;
                end
            end
            RUN: begin
                if (!en) begin
                    // A boundary coinciding with en falling still takes the pending config.
                    apply     = boundary & pend_vld;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (boundary) begin
                    apply   = pend_vld;
                    cnt_nxt = '0;
                    if (pend_vld && (pend_period < TWO)) begin
                        state_nxt = HOLD;
                    end
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            HOLD: begin
                cnt_nxt = '0;
                if (!en) begin
                    state_nxt = IDLE;
                end else begin
                    apply = pend_vld;
                    if (pend_vld && (pend_period >= TWO)) begin
                        state_nxt = RUN;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // High phase is decided from the current count; output is suppressed when leaving or not in RUN.
    assign sq_nxt   = (state == RUN) && (state_nxt == RUN) && (cnt < act_high);
    assign tick_nxt = (state_nxt == RUN) && (cnt_nxt == '0);

    // All FSM, configuration and output registers, asynchronously cleared.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            act_period  <= '0;
            act_high    <= '0;
            pend_period <= '0;
            pend_high   <= '0;
            pend_vld    <= 1'b0;
            sq_out      <= 1'b0;
            period_tick <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sq_out      <= sq_nxt;
            period_tick <= tick_nxt;
            if (apply) begin
                act_period <= pend_period;
                act_high   <= pend_high;
                pend_vld   <= 1'b0;
            end
            // accept and apply are mutually exclusive: apply needs a full slot, accept an empty one.
            if (accept) begin
                pend_period <= cfg_period;
                pend_high   <= cfg_high;
                pend_vld    <= 1'b1;
                if (cfg_period < TWO) begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_square_wave_gen.sv
// Self-checking bench for square_wave_gen: directed scenarios plus randomized traffic.
// Outputs are compared every cycle against a cycle-level behavioural model.
// Configuration offers hold cfg_valid until accepted.
module tb_square_wave_gen;

    localparam int W = 8;

    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic         en;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cfg_high;
    logic         cfg_valid;
    logic         cfg_ready;
    logic         sq_out;
    logic         period_tick;
    logic         cfg_err;

    square_wave_gen #(.CNT_W(W)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .en          (en),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .sq_out      (sq_out),
        .period_tick (period_tick),
        .cfg_err     (cfg_err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // running / holding flags, position within the period, active and pending settings
    bit          m_run, m_hold, m_pend, m_err, m_sq;
    int unsigned m_pos, m_per, m_hi, p_per, p_hi;

    function automatic void model_reset();
        m_run = 0; m_hold = 0; m_pend = 0; m_err = 0; m_sq = 0;
        m_pos = 0; m_per = 0; m_hi = 0; p_per = 0; p_hi = 0;
    endfunction

    function automatic void take_pending();
        if (m_pend) begin
            m_per  = p_per;
            m_hi   = p_hi;
            m_pend = 0;
        end
    endfunction

    function automatic void model_step(input bit e, input bit v, input int unsigned p, input int unsigned h);
        bit was_run, high_now, pend0, ends;
        was_run  = m_run;
        high_now = (m_pos < m_hi);
        pend0    = m_pend;
        ends     = m_run && (m_pos + 1 == m_per);
        if (!e) begin
            if ((!m_run && !m_hold) || ends) take_pending();
            m_run = 0; m_hold = 0; m_pos = 0;
        end else if (m_run) begin
            if (ends) begin
                take_pending();
                m_pos = 0;
                if (m_per < 2) begin m_run = 0; m_hold = 1; end
            end else begin
                m_pos++;
            end
        end else begin
            take_pending();
            m_run  = (m_per >= 2);
            m_hold = !m_run;
            m_pos  = 0;
        end
        m_sq = was_run && m_run && high_now;
        if (v && !pend0) begin
            p_per  = p;
            p_hi   = h;
            m_pend = 1;
            if (p < 2) m_err = 1;
        end
    endfunction

    task automatic compare_outputs();
        check("sq_out",      sq_out,      m_sq);
        check("period_tick", period_tick, (m_run && m_pos == 0));
        check("cfg_ready",   cfg_ready,   !m_pend);
        check("cfg_err",     cfg_err,     m_err);
    endtask

    bit cur_en = 0;

    // Called at a falling edge: check, drive, advance model and DUT by one cycle.
    task automatic cycle(input bit v, input logic [W-1:0] p, input logic [W-1:0] h);
        compare_outputs();
        en         = cur_en;
        cfg_valid  = v;
        cfg_period = p;
        cfg_high   = h;
        model_step(cur_en, v, p, h);
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic offer(input logic [W-1:0] p, input logic [W-1:0] h);
        bit acc;
        int n;
        n = 0;
        do begin
            acc = !m_pend;
            cycle(1'b1, p, h);
            n++;
        end while (!acc && n < 300);
        check("offer_accepted", acc, 1);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!cfg_ready && n < 300) begin
            cycle(1'b0, '0, '0);
            n++;
        end
        check("wait_ready", cfg_ready, 1);
    endtask

    // Reset is raised between clock edges so its effect must be visible before any edge.
    task automatic do_reset();
        sys_rst = 1'b1;
        #1;
        check("rst_sq_out",      sq_out,      0);
        check("rst_period_tick", period_tick, 0);
        check("rst_cfg_ready",   cfg_ready,   1);
        check("rst_cfg_err",     cfg_err,     0);
        model_reset();
        @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    int k, ticks, highs;
    bit off_v;
    logic [W-1:0] off_p, off_h;

    task automatic count_run(input int n);
        ticks = 0;
        highs = 0;
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, '0, '0);
            ticks += int'(period_tick);
            highs += int'(sq_out);
        end
    endtask

    initial begin
        en = 0; cfg_valid = 0; cfg_period = '0; cfg_high = '0; sys_rst = 1'b0;
        model_reset();
        do_reset();

        // 10/3 configured while idle, then enabled
        offer(8'd10, 8'd3);
        check("ready_low_after_accept", cfg_ready, 0);
        k = 0;
        while (!cfg_ready && k < 5) begin cycle(1'b0, '0, '0); k++; end
        check("ready_latency", k, 1);
        cur_en = 1;
        count_run(30);
        check("p10_ticks", ticks, 3);
        check("p10_highs", highs, 9);

        // mid-period change at cnt=5 takes effect only at the boundary
        cycle(1'b0, '0, '0);
        check("tick_at_wrap", period_tick, 1);
        repeat (5) cycle(1'b0, '0, '0);
        offer(8'd4, 8'd2);
        k = 0;
        while (!cfg_ready && k < 50) begin cycle(1'b0, '0, '0); k++; end
        check("ready_held_to_boundary", k, 4);
        check("tick_on_new_period", period_tick, 1);
        k = 0;
        do begin cycle(1'b0, '0, '0); k++; end while (!period_tick && k < 50);
        check("new_period_len", k, 4);

        // 100% duty then 0% duty
        offer(8'd8, 8'd8);
        wait_ready(k);
        count_run(16);
        check("full_duty_highs", highs, 16);
        check("full_duty_ticks", ticks, 2);
        offer(8'd8, 8'd0);
        wait_ready(k);
        count_run(16);
        check("zero_duty_highs", highs, 0);
        check("zero_duty_ticks", ticks, 2);

        // illegal period -> HOLD and sticky error, then recover
        offer(8'd1, 8'd0);
        wait_ready(k);
        check("err_after_bad_period", cfg_err, 1);
        count_run(3);
        check("hold_ticks", ticks, 0);
        check("hold_highs", highs, 0);
        offer(8'd6, 8'd3);
        wait_ready(k);
        check("hold_to_run_tick", period_tick, 1);
        count_run(12);
        check("p6_ticks", ticks, 2);
        check("err_sticky", cfg_err, 1);

        // en dropped at cnt=2 of 10/5, then raised again
        offer(8'd10, 8'd5);
        wait_ready(k);
        repeat (2) cycle(1'b0, '0, '0);
        check("sq_high_before_drop", sq_out, 1);
        cur_en = 0;
        cycle(1'b0, '0, '0);
        check("sq_low_after_drop", sq_out, 0);
        repeat (3) cycle(1'b0, '0, '0);
        cur_en = 1;
        cycle(1'b0, '0, '0);
        check("restart_tick", period_tick, 1);
        repeat (2) cycle(1'b0, '0, '0);
        check("sq_high_before_reset", sq_out, 1);
        compare_outputs();
        do_reset();

        // randomized traffic
        off_v = 0; off_p = '0; off_h = '0;
        for (int i = 0; i < 4000; i++) begin
            bit acc;
            int r;
            if (cur_en ? ($urandom_range(99) < 2) : ($urandom_range(99) < 15)) cur_en = ~cur_en;
            if ($urandom_range(999) == 0) do_reset();
            if (!off_v && $urandom_range(9) == 0) begin
                off_v = 1;
                r = int'($urandom_range(19));
                off_p = (r < 18) ? W'(r) : W'(255 - (r - 18));
                r = int'(off_p) + 2;
                if (r > 255) r = 255;
                off_h = W'($urandom_range(r));
            end
            acc = off_v && !m_pend;
            if (off_v) cycle(1'b1, off_p, off_h);
            else       cycle(1'b0, W'($urandom), W'($urandom));
            if (acc) off_v = 0;
        end
        compare_outputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/square_wave_gen.md
SQUARE_WAVE_GEN -- requirements
Module: square_wave_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of the period and high-time counts.
REQ-002 The block SHALL have port sys_clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port en, input, 1 bit: run enable, level-sensitive.
REQ-005 The block SHALL have port cfg_period, input, CNT_W bits: requested period in sys_clk cycles.
REQ-006 The block SHALL have port cfg_high, input, CNT_W bits: requested high time in sys_clk cycles.
REQ-007 The block SHALL have port cfg_valid, input, 1 bit: a configuration is offered.
REQ-008 The block SHALL have port cfg_ready, output, 1 bit: the block can accept a configuration.
REQ-009 The block SHALL have port sq_out, output, 1 bit: generated square wave, registered.
REQ-010 The block SHALL have port period_tick, output, 1 bit: one-cycle pulse on the first cycle of each period.
REQ-011 The block SHALL have port cfg_err, output, 1 bit: sticky flag, set when an illegal period was accepted.

Function
REQ-012 The block SHALL accept a configuration on a cycle where cfg_valid and cfg_ready are both 1, capturing cfg_period and cfg_high into a pending register.
REQ-013 cfg_ready SHALL be 1 when no pending configuration exists, and 0 from the cycle after acceptance until the pending configuration is applied.
REQ-014 The state machine SHALL have three states: IDLE, RUN and HOLD.
REQ-015 In IDLE, a pending configuration SHALL be applied on the following cycle.
REQ-016 In RUN, a pending configuration SHALL be applied only at the period boundary, i.e. on the cycle where cnt == active_period-1; mid-period changes are forbidden.
REQ-017 Transition IDLE->RUN: en=1 and the active period is >= 2; cnt SHALL be 0 and period_tick SHALL pulse on the first RUN cycle.
REQ-018 Transition IDLE->HOLD: en=1 and the active period is < 2.
REQ-019 Transition RUN->IDLE and HOLD->IDLE: en=0, taken immediately; cnt SHALL clear, sq_out SHALL go 0 on the next cycle, and the pending configuration SHALL be retained.
REQ-020 Transition RUN->HOLD: a configuration with period < 2 is applied at a boundary.
REQ-021 Transition HOLD->RUN: a configuration with period >= 2 is applied.
REQ-022 In RUN, cnt SHALL count 0..active_period-1 and wrap to 0; period_tick SHALL be 1 on every cycle where cnt == 0.
REQ-023 sq_out SHALL be 1 when cnt < active_high and 0 otherwise, with one register stage, so sq_out lags cnt by 1 cycle.
REQ-024 If active_high >= active_period, sq_out SHALL be constant 1 (100% duty).
REQ-025 If active_high == 0, sq_out SHALL be constant 0; period_tick SHALL still pulse.
REQ-026 Comparisons SHALL be unsigned at full CNT_W width, with no truncation.
REQ-027 In HOLD and in IDLE, sq_out SHALL be 0 and period_tick SHALL be 0.
REQ-028 Accepting any configuration with cfg_period < 2 SHALL set cfg_err; only reset clears it.
REQ-029 If cfg_valid is asserted while cfg_ready=0, the request SHALL be ignored; the offering side holds cfg_valid until it sees cfg_ready.
REQ-030 If en falls on the same cycle as a boundary with a configuration pending, the configuration SHALL be applied and the state SHALL go to IDLE.

Reset
REQ-031 While sys_rst=1 the block SHALL asynchronously force: state IDLE, cnt 0, active_period 0, active_high 0, no pending configuration, sq_out 0, period_tick 0, cfg_err 0, cfg_ready 1.
REQ-032 Reset asserted mid-period SHALL abort the waveform immediately, with no completion of the current period.
REQ-033 After reset deassertion, the block SHALL need a configuration to be accepted before RUN can be entered.

Verification
REQ-034 Reset, then configuration period=10, high=3 accepted, then en=1 -> sq_out repeats 3 cycles high and 7 cycles low, period_tick every 10 cycles, cfg_ready back to 1 within 2 cycles.
REQ-035 While running 10/3, offer period=4, high=2 at cnt=5 -> the 10/3 period completes unchanged, the next period is 4/2, and cfg_ready stays 0 until that boundary.
REQ-036 Configuration period=8, high=8, then high=0 -> sq_out constant 1, then constant 0, period_tick every 8 cycles in both cases.
REQ-037 Configuration period=1 -> state HOLD, cfg_err=1, sq_out=0; a later configuration of 6/3 -> RUN, with cfg_err still 1.
REQ-038 en dropped at cnt=2 of a 10/5 waveform -> sq_out 0 on the next cycle; en re-raised -> the period restarts from cnt=0 with period_tick.
REQ-039 sys_rst pulsed mid-high-phase -> all outputs read their reset values in the same cycle as assertion, asynchronously.
